// File: rtl/pacman_game_pkg.sv
// Shared game types and scoring constants for the Pac-Man game sequencer
// and the ghost controllers it drives.
package pacman_game_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READY       = 3'd1,
        PLAY        = 3'd2,
        DYING       = 3'd3,
        LEVEL_CLEAR = 3'd4,
        GAME_OVER   = 3'd5
    } game_state_t;

    localparam int PELLET_PTS     = 10;
    localparam int POWER_PTS      = 50;
    localparam int GHOST_BASE_PTS = 200;

    localparam int BLINKY     = 0;
    localparam int PINKY      = 1;
    localparam int INKY       = 2;
    localparam int CLYDE      = 3;
    localparam int NUM_GHOSTS = 4;

    localparam int SCORE_W = 20;

    // Ghost combo index saturates at 3, i.e. 200 << 3 = 1600 points.
    function automatic logic [1:0] combo_inc(input logic [1:0] combo);
        return (combo == 2'd3) ? combo : combo + 2'd1;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_score_accum.sv
// Per-frame score accumulator: sums pellet/power/ghost points, tracks the
// ghost combo, saturates the score and flags the one-time extra life.
module score_accum
    import pacman_game_pkg::*;
#(
    parameter int EXTRA_LIFE_SCORE = 10000,
    parameter int SCORE_MAX        = 999990
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  clear,
    input  logic                  score_en,
    input  logic                  pellet_eaten,
    input  logic                  power_eaten,
    input  logic [NUM_GHOSTS-1:0] ghost_eaten,
    output logic [SCORE_W-1:0]    score,
    output logic                  extra_life
);

    localparam logic [SCORE_W-1:0] EXTRA_THR = SCORE_W'(EXTRA_LIFE_SCORE);
    localparam logic [SCORE_W-1:0] SAT_VAL   = SCORE_W'(SCORE_MAX);

    logic [1:0]         combo;
    logic [1:0]         combo_nxt;
    logic               extra_given;
    logic [SCORE_W:0]   points_add;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_nxt;

    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // so this block can never infer a latch.
        combo_nxt  = power_eaten ? 2'd0 : combo;
        points_add = '0;
        if (pellet_eaten)
            points_add = points_add + (SCORE_W+1)'(PELLET_PTS);
        if (power_eaten)
            points_add = points_add + (SCORE_W+1)'(POWER_PTS);
        // Ghosts are credited in index order so the combo climbs within one frame.
        for (int i = BLINKY; i <= CLYDE; i++) begin
            if (ghost_eaten[i]) begin
                points_add = points_add + ((SCORE_W+1)'(GHOST_BASE_PTS) << combo_nxt);
                combo_nxt  = combo_inc(combo_nxt);
            end
        end
        score_sum  = {1'b0, score} + points_add;
        score_nxt  = (score_sum > {1'b0, SAT_VAL}) ? SAT_VAL : score_sum[SCORE_W-1:0];
        extra_life = score_en && !extra_given && (score < EXTRA_THR) && (score_nxt >= EXTRA_THR);
    end

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            score       <= '0;
            combo       <= 2'd0;
            extra_given <= 1'b0;
        end else if (score_en) begin
            score <= score_nxt;
            combo <= combo_nxt;
            if (extra_life)
                extra_given <= 1'b1;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Central game sequencer: start/death/level-clear FSM, lives and level,
// and the one-frame control strobes consumed by the ghost controllers.
module game_flow_ctrl
    import pacman_game_pkg::*;
#(
    parameter int          PELLETS_PER_MAP  = 244,
    parameter int          READY_FRAMES     = 120,
    parameter int          DYING_FRAMES     = 90,
    parameter int          CLEAR_FRAMES     = 120,
    parameter int          START_LIVES      = 3,
    parameter int          EXTRA_LIFE_SCORE = 10000,
    parameter int          SCORE_MAX        = 999990,
    parameter logic [7:0]  START_KEY        = 8'h28
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic [7:0]         keycode,
    input  logic               pellet_eaten,
    input  logic               power_eaten,
    input  logic [3:0]         pacman_hit,
    input  logic [3:0]         ghost_eaten,
    output logic               soft_reset,
    output logic               hard_reset,
    output logic               new_map,
    output logic               ate_pellet,
    output logic [19:0]        points_eaten,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic [7:0]         level,
    output logic               game_over,
    output logic [2:0]         game_state
);

    localparam logic [19:0] PPM        = 20'(PELLETS_PER_MAP);
    localparam logic [7:0]  READY_LAST = 8'(READY_FRAMES - 1);
    localparam logic [7:0]  DYING_LAST = 8'(DYING_FRAMES - 1);
    localparam logic [7:0]  CLEAR_LAST = 8'(CLEAR_FRAMES - 1);
    localparam logic [2:0]  LIVES_INIT = 3'(START_LIVES);

    game_state_t state;
    logic [7:0]  frame_cnt;
    logic        in_play;
    logic        start_game;
    logic        extra_life;
    logic [19:0] points_sum;
    logic [19:0] points_nxt;

    assign game_state = state;
    assign in_play    = frame_tick && (state == PLAY);
    assign start_game = frame_tick && (state == IDLE || state == GAME_OVER) && (keycode == START_KEY);
    assign points_sum = points_eaten + 20'(pellet_eaten) + 20'(power_eaten);
    assign points_nxt = (points_sum >= PPM) ? PPM : points_sum;

    score_accum #(
        .EXTRA_LIFE_SCORE (EXTRA_LIFE_SCORE),
        .SCORE_MAX        (SCORE_MAX)
    ) u_score_accum (
        .Clk          (Clk),
        .Reset        (Reset),
        .clear        (start_game),
        .score_en     (in_play),
        .pellet_eaten (pellet_eaten),
        .power_eaten  (power_eaten),
        .ghost_eaten  (ghost_eaten),
        .score        (score),
        .extra_life   (extra_life)
    );

    // NOTE: all state below is sequential, so it is updated only with
    // non-blocking assignments; every register then sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            frame_cnt    <= 8'd0;
            lives        <= LIVES_INIT;
            level        <= 8'd1;
            points_eaten <= '0;
            soft_reset   <= 1'b0;
            hard_reset   <= 1'b0;
            new_map      <= 1'b0;
            ate_pellet   <= 1'b0;
            game_over    <= 1'b0;
        end else if (frame_tick) begin
            // A strobe window closes on the frame tick after the one that opened it.
            soft_reset <= 1'b0;
            hard_reset <= 1'b0;
            new_map    <= 1'b0;
            ate_pellet <= 1'b0;
            frame_cnt  <= frame_cnt + 8'd1;
            case (state)
                IDLE, GAME_OVER: begin
                    if (start_game) begin
                        hard_reset   <= 1'b1;
                        lives        <= LIVES_INIT;
                        level        <= 8'd1;
                        points_eaten <= '0;
                        game_over    <= 1'b0;
                        state        <= READY;
                        frame_cnt    <= 8'd0;
                    end
                end
                READY: begin
                    if (frame_cnt == READY_LAST) begin
                        state     <= PLAY;
                        frame_cnt <= 8'd0;
                    end
                end
                PLAY: begin
                    ate_pellet   <= power_eaten;
                    points_eaten <= points_nxt;
                    if (extra_life && lives != 3'd7)
                        lives <= lives + 3'd1;
                    // Clearing the maze takes priority over a same-frame hit.
                    if (points_nxt == PPM) begin
                        state     <= LEVEL_CLEAR;
                        frame_cnt <= 8'd0;
                    end else if (|pacman_hit) begin
                        state     <= DYING;
                        frame_cnt <= 8'd0;
                    end
                end
                DYING: begin
                    if (frame_cnt == DYING_LAST) begin
                        lives     <= lives - 3'd1;
                        frame_cnt <= 8'd0;
                        if (lives == 3'd1) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            soft_reset <= 1'b1;
                            state      <= READY;
                        end
                    end
                end
                LEVEL_CLEAR: begin
                    if (frame_cnt == CLEAR_LAST) begin
                        new_map      <= 1'b1;
                        level        <= (level == 8'd255) ? 8'd1 : level + 8'd1;
                        points_eaten <= '0;
                        state        <= READY;
                        frame_cnt    <= 8'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: a frame-level reference model pushes
// expected outputs per frame tick, which are popped after the DUT's edge.
module tb_game_flow_ctrl;
    import pacman_game_pkg::*;

    localparam int         PPM   = 10;
    localparam int         RF    = 120;
    localparam int         DF    = 90;
    localparam int         CF    = 120;
    localparam int         SL    = 3;
    localparam int         EXTRA = 10000;
    localparam int         SMAX  = 999990;
    localparam logic [7:0] START = 8'h28;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic [7:0]  keycode;
    logic        pellet_eaten;
    logic        power_eaten;
    logic [3:0]  pacman_hit;
    logic [3:0]  ghost_eaten;
    logic        soft_reset, hard_reset, new_map, ate_pellet, game_over;
    logic [19:0] points_eaten;
    logic [19:0] score;
    logic [2:0]  lives;
    logic [7:0]  level;
    logic [2:0]  game_state;

    always #5 Clk = ~Clk;

    game_flow_ctrl #(
        .PELLETS_PER_MAP  (PPM),
        .READY_FRAMES     (RF),
        .DYING_FRAMES     (DF),
        .CLEAR_FRAMES     (CF),
        .START_LIVES      (SL),
        .EXTRA_LIFE_SCORE (EXTRA),
        .SCORE_MAX        (SMAX),
        .START_KEY        (START)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .keycode      (keycode),
        .pellet_eaten (pellet_eaten),
        .power_eaten  (power_eaten),
        .pacman_hit   (pacman_hit),
        .ghost_eaten  (ghost_eaten),
        .soft_reset   (soft_reset),
        .hard_reset   (hard_reset),
        .new_map      (new_map),
        .ate_pellet   (ate_pellet),
        .points_eaten (points_eaten),
        .score        (score),
        .lives        (lives),
        .level        (level),
        .game_over    (game_over),
        .game_state   (game_state)
    );

    typedef struct {
        int state, score, lives, level, points;
        bit hr, sr, nm, ap, go;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    int   n_tests = 0;
    int   n_fail  = 0;

    game_state_t m_state;
    int          m_cnt, m_score, m_combo, m_lives, m_level, m_points;
    bit          m_extra, m_go;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = IDLE; m_cnt = 0; m_score = 0; m_combo = 0;
        m_lives = SL; m_level = 1; m_points = 0; m_extra = 0; m_go = 0;
        held = '{state: 0, score: 0, lives: SL, level: 1, points: 0,
                 hr: 0, sr: 0, nm: 0, ap: 0, go: 0};
    endtask

    // Reference behaviour for one frame tick; pushes the expected outputs.
    task automatic model_frame(input logic [7:0] k, input bit pel, input bit pow,
                               input logic [3:0] hit, input logic [3:0] gh);
        exp_t e;
        int   add, old_score;
        bit   hr, sr, nm, ap;
        hr = 0; sr = 0; nm = 0; ap = 0;
        case (m_state)
            IDLE, GAME_OVER: if (k == START) begin
                hr = 1; m_lives = SL; m_level = 1; m_score = 0; m_points = 0;
                m_combo = 0; m_extra = 0; m_go = 0; m_state = READY; m_cnt = 0;
            end
            READY: if (m_cnt == RF - 1) begin m_state = PLAY; m_cnt = 0; end
                   else m_cnt++;
            PLAY: begin
                add = 0;
                if (pel) add += 10;
                if (pow) begin add += 50; m_combo = 0; ap = 1; end
                for (int i = 0; i < 4; i++)
                    if (gh[i]) begin
                        add += 200 * (1 << m_combo);
                        if (m_combo < 3) m_combo++;
                    end
                old_score = m_score;
                m_score   = (m_score + add > SMAX) ? SMAX : m_score + add;
                if (!m_extra && old_score < EXTRA && m_score >= EXTRA) begin
                    m_extra = 1;
                    if (m_lives < 7) m_lives++;
                end
                m_points = m_points + int'(pel) + int'(pow);
                if (m_points > PPM) m_points = PPM;
                if (m_points == PPM) begin m_state = LEVEL_CLEAR; m_cnt = 0; end
                else if (hit != 4'h0) begin m_state = DYING; m_cnt = 0; end
            end
            DYING: if (m_cnt == DF - 1) begin
                m_lives--; m_cnt = 0;
                if (m_lives == 0) begin m_state = GAME_OVER; m_go = 1; end
                else begin sr = 1; m_state = READY; end
            end else m_cnt++;
            LEVEL_CLEAR: if (m_cnt == CF - 1) begin
                nm = 1; m_level = (m_level == 255) ? 1 : m_level + 1;
                m_points = 0; m_state = READY; m_cnt = 0;
            end else m_cnt++;
            default: ;
        endcase
        e = '{state: int'(m_state), score: m_score, lives: m_lives, level: m_level,
              points: m_points, hr: hr, sr: sr, nm: nm, ap: ap, go: m_go};
        sb_q.push_back(e);
    endtask

    // One frame = 4 Clk cycles; outputs are sampled on falling edges.
    task automatic frame(input logic [7:0] k, input bit pel, input bit pow,
                         input logic [3:0] hit, input logic [3:0] gh);
        exp_t e;
        @(negedge Clk);
        check("hard_reset_hold", int'(hard_reset), int'(held.hr));
        check("soft_reset_hold", int'(soft_reset), int'(held.sr));
        check("new_map_hold",    int'(new_map),    int'(held.nm));
        check("ate_pellet_hold", int'(ate_pellet), int'(held.ap));
        keycode = k; pellet_eaten = pel; power_eaten = pow;
        pacman_hit = hit; ghost_eaten = gh; frame_tick = 1'b1;
        model_frame(k, pel, pow, hit, gh);
        @(negedge Clk);
        frame_tick = 1'b0; keycode = 8'h00; pellet_eaten = 1'b0;
        power_eaten = 1'b0; pacman_hit = 4'h0; ghost_eaten = 4'h0;
        e = sb_q.pop_front();
        check("state",      int'(game_state),   e.state);
        check("score",      int'(score),        e.score);
        check("lives",      int'(lives),        e.lives);
        check("level",      int'(level),        e.level);
        check("points",     int'(points_eaten), e.points);
        check("hard_reset", int'(hard_reset),   int'(e.hr));
        check("soft_reset", int'(soft_reset),   int'(e.sr));
        check("new_map",    int'(new_map),      int'(e.nm));
        check("ate_pellet", int'(ate_pellet),   int'(e.ap));
        check("game_over",  int'(game_over),    int'(e.go));
        held = e;
        repeat (2) @(negedge Clk);
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) frame(8'h00, 1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"},  int'(game_state), int'(IDLE));
        check({tag, "_score"},  int'(score), 0);
        check({tag, "_lives"},  int'(lives), SL);
        check({tag, "_level"},  int'(level), 1);
        check({tag, "_points"}, int'(points_eaten), 0);
        check({tag, "_strobes"}, int'({soft_reset, hard_reset, new_map, ate_pellet, game_over}), 0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check_reset_state(tag);
        Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; keycode = 8'h00; pellet_eaten = 1'b0;
        power_eaten = 1'b0; pacman_hit = 4'h0; ghost_eaten = 4'h0;
        model_reset();
        repeat (3) @(negedge Clk);
        check_reset_state("reset");
        Reset = 1'b0;

        // Non-start key is ignored, then the start key opens a new game.
        frame(8'h11, 1'b0, 1'b0, 4'h0, 4'h0);
        frame(START, 1'b0, 1'b0, 4'h0, 4'h0);
        check("start_hard_reset", int'(hard_reset), 1);
        idle_frames(RF);
        check("play_entered", int'(game_state), int'(PLAY));
        check("play_lives", int'(lives), 3);

        for (int i = 0; i < 5; i++) frame(8'h00, 1'b1, 1'b0, 4'h0, 4'h0);
        frame(8'h00, 1'b0, 1'b1, 4'h0, 4'h0);
        check("pellets_score", int'(score), 100);
        check("pellets_points", int'(points_eaten), 6);
        check("power_ate_pellet", int'(ate_pellet), 1);

        frame(8'h00, 1'b0, 1'b0, 4'h0, 4'b0011);
        check("combo_600", int'(score), 700);
        frame(8'h00, 1'b0, 1'b0, 4'h0, 4'b0100);
        check("combo_800", int'(score), 1500);
        frame(8'h00, 1'b0, 1'b0, 4'h0, 4'b1000);
        check("combo_1600", int'(score), 3100);
        frame(8'h00, 1'b0, 1'b0, 4'h0, 4'b1111);
        check("below_extra_lives", int'(lives), 3);
        frame(8'h00, 1'b0, 1'b0, 4'h0, 4'b1111);
        check("extra_life", int'(lives), 4);
        frame(8'h00, 1'b0, 1'b0, 4'h0, 4'b1111);
        check("extra_once", int'(lives), 4);
        frame(8'h00, 1'b0, 1'b1, 4'h0, 4'h0);
        frame(8'h00, 1'b0, 1'b0, 4'h0, 4'b0001);
        check("combo_reset", int'(score), 22550);

        // Death: lives drop after the animation, score and points kept.
        frame(8'h00, 1'b0, 1'b0, 4'b0100, 4'h0);
        check("dying", int'(game_state), int'(DYING));
        idle_frames(DF);
        check("death_lives", int'(lives), 3);
        check("death_soft_reset", int'(soft_reset), 1);
        check("death_score", int'(score), 22550);
        check("death_points", int'(points_eaten), 7);
        idle_frames(RF);

        // Last pellet and a hit in the same frame: level clear wins.
        frame(8'h00, 1'b1, 1'b0, 4'h0, 4'h0);
        frame(8'h00, 1'b1, 1'b0, 4'h0, 4'h0);
        frame(8'h00, 1'b1, 1'b0, 4'b0010, 4'h0);
        check("clear_wins", int'(game_state), int'(LEVEL_CLEAR));
        check("clear_score", int'(score), 22580);
        idle_frames(CF);
        check("new_map_level", int'(level), 2);
        check("new_map_points", int'(points_eaten), 0);
        idle_frames(RF);

        for (int i = 0; i < 160; i++) frame(8'h00, 1'b0, 1'b0, 4'h0, 4'b1111);
        check("score_saturated", int'(score), SMAX);

        // Three deaths end the game.
        for (int d = 0; d < 3; d++) begin
            frame(8'h00, 1'b0, 1'b0, 4'b0001, 4'h0);
            idle_frames(DF);
            if (d < 2) idle_frames(RF);
        end
        check("game_over_state", int'(game_state), int'(GAME_OVER));
        check("game_over_lives", int'(lives), 0);
        check("game_over_flag", int'(game_over), 1);
        idle_frames(2);
        check("game_over_score_held", int'(score), SMAX);

        // Restart from GAME_OVER, then reset inside the hard_reset window.
        frame(START, 1'b0, 1'b0, 4'h0, 4'h0);
        check("restart_score", int'(score), 0);
        apply_reset("reset_in_window");

        // Reset during the death animation.
        frame(START, 1'b0, 1'b0, 4'h0, 4'h0);
        idle_frames(RF);
        frame(8'h00, 1'b1, 1'b0, 4'b1000, 4'h0);
        idle_frames(10);
        apply_reset("reset_in_dying");
        idle_frames(2);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
